// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: CPU MemOp encoding,
// responder FSM states and the latched request payload.
package dmem_pkg;

  localparam logic [2:0] MOP_B  = 3'b000;
  localparam logic [2:0] MOP_H  = 3'b001;
  localparam logic [2:0] MOP_W  = 3'b010;
  localparam logic [2:0] MOP_BU = 3'b100;
  localparam logic [2:0] MOP_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  typedef struct packed {
    logic        wen;
    logic [2:0]  memop;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmem_req_t;

  // Unsigned-extend loads have no store counterpart.
  function automatic logic memop_legal(input logic [2:0] memop, input logic wen);
    case (memop)
      MOP_B, MOP_H, MOP_W: return 1'b1;
      MOP_BU, MOP_HU:      return !wen;
      default:             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response handshake bundle between the core's load/store path
// (master) and the data-memory responder (slave).
interface data_mem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [2:0]  req_memop;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_wen, req_memop, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wen, req_memop, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/dmem_lane_fmt.sv
// Combinational lane formatter: store byte-lane merge into the old word and
// load lane extract with sign/zero extension.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [2:0]  memop,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] old_word,
  output logic [31:0] new_word_c,
  output logic [31:0] rdata_c
);

  logic [3:0]  be;
  logic [31:0] wrep;
  logic [31:0] shifted;

  // Replicate store data across lanes, then pick per byte enable.
  always_comb begin
    be         = 4'b0000;
    wrep       = wdata;
    new_word_c = old_word;
    case (memop)
      MOP_B: begin
        be   = 4'b0001 << lane;
        wrep = {4{wdata[7:0]}};
      end
      MOP_H: begin
        be   = 4'b0011 << lane;
        wrep = {2{wdata[15:0]}};
      end
      MOP_W:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    for (int i = 0; i < 4; i++) begin
      if (be[i]) new_word_c[8*i +: 8] = wrep[8*i +: 8];
    end
  end

  always_comb begin
    shifted = old_word >> {lane, 3'b000};
    case (memop)
      MOP_B:   rdata_c = {{24{shifted[7]}}, shifted[7:0]};
      MOP_BU:  rdata_c = {24'h000000, shifted[7:0]};
      MOP_H:   rdata_c = {{16{shifted[15]}}, shifted[15:0]};
      MOP_HU:  rdata_c = {16'h0000, shifted[15:0]};
      MOP_W:   rdata_c = old_word;
      default: rdata_c = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data-memory responder for the CPU data port.
// Build option: DMEM_MISALIGN_TRAP_EN faults misaligned half/word accesses
// instead of force-aligning them.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus
);

  localparam int unsigned AW    = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = 4;

  logic [31:0] mem [DEPTH_WORDS];

  dmem_state_e state_q;
  logic [CNT_W-1:0] cnt_q;
  dmem_req_t   req_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;

  logic [31:0]   offset;
  logic          in_range;
  logic          is_half;
  logic          is_word;
  logic [1:0]    lane;
  logic [1:0]    lane_eff;
  logic          fault;
  logic [AW-1:0] word_idx;
  logic          access_now;
  logic [31:0]   old_word;
  logic [31:0]   new_word_c;
  logic [31:0]   rdata_c;

  // Address decode and fault classification of the latched request.
  always_comb begin
    offset   = req_q.addr - BASE_ADDR;
    in_range = (offset[31:AW+2] == '0);
    lane     = offset[1:0];
    word_idx = offset[AW+1:2];
    is_half  = (req_q.memop == MOP_H) || (req_q.memop == MOP_HU);
    is_word  = (req_q.memop == MOP_W);
    if (is_half)      lane_eff = {lane[1], 1'b0};
    else if (is_word) lane_eff = 2'b00;
    else              lane_eff = lane;
    fault = !in_range || !memop_legal(req_q.memop, req_q.wen);
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((is_half && lane[0]) || (is_word && (lane != 2'b00))) fault = 1'b1;
`endif
  end

  assign old_word   = mem[word_idx];
  assign access_now = (state_q == ST_WAIT) && (cnt_q == '0);

  dmem_lane_fmt u_lane_fmt (
    .memop      (req_q.memop),
    .lane       (lane_eff),
    .wdata      (req_q.wdata),
    .old_word   (old_word),
    .new_word_c (new_word_c),
    .rdata_c    (rdata_c)
  );

  // Storage is not reset; a commit edge that coincides with rst is dropped.
  always_ff @(posedge clk) begin
    if (!rst && access_now && req_q.wen && !fault) begin
      mem[word_idx] <= new_word_c;
    end
  end

  // Every access passes through WAIT so the commit lands exactly LATENCY
  // edges after accept, including LATENCY=1 (counter loaded with zero).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      req_q        <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          req_ready_q <= 1'b1;
          if (bus.req_valid && req_ready_q) begin
            req_q       <= '{wen:   bus.req_wen,
                             memop: bus.req_memop,
                             addr:  bus.req_addr,
                             wdata: bus.req_wdata};
            cnt_q       <= CNT_W'(LATENCY - 1);
            req_ready_q <= 1'b0;
            state_q     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= fault;
            resp_rdata_q <= (fault || req_q.wen) ? 32'h0000_0000 : rdata_c;
            state_q      <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

endmodule
